msg_sequencer: RTL
==================

# msg_sequencer

Parametrised message transmitter: streams up to NUM_MSGS stored ASCII messages, selected by a bit mask, one byte at a time over a valid/ready handshake into the UART serialiser. It appends a separator byte after every message. It supports a one-shot trigger and a periodic auto-repeat mode. It sits between the debounced front-panel controls and the serialiser, replacing the fixed four-word hard-coded sequencer with a ROM-driven, length-table-driven engine.

## Interface
- NUM_MSGS, default 4: number of stored messages; index width MI_W = max(1, clog2(NUM_MSGS)).
- MSG_LEN_MAX, default 16: maximum bytes per message; char-index width CI_W = clog2(MSG_LEN_MAX+1).
- DATA_W, default 8: width of a transmitted character.
- SEP_CHAR, default 8'h20: separator byte sent after each message.
- AUTO_PERIOD, default 2**25: sysclk cycles between auto-mode starts; must be ≥ 2.
- sysclk, in, 1: single clock; all logic on its rising edge.
- rst, in, 1: reset, synchronous, active-high.
- msg_sel, in, NUM_MSGS: bit i set means message i is sent; sampled only at start.
- go, in, 1: single-cycle start pulse (already debounced).
- auto_en, in, 1: level; enables periodic starts.
- tx_data, out, DATA_W: character to the serialiser.
- tx_valid, out, 1: tx_data is valid.
- tx_ready, in, 1: serialiser accepts the character this cycle.
- busy, out, 1: high from start until the last separator is accepted.
- done, out, 1: one-cycle pulse on completion of a run.
- cur_msg, out, MI_W: index of the message being sent; 0 when idle.

## Operation
- Reset values: tx_valid=0, tx_data=0, busy=0, done=0, cur_msg=0, auto counter=0, state=IDLE.
- Start event: go=1, or the auto tick (auto_en=1 and counter reaches AUTO_PERIOD-1), while in IDLE. If both occur in the same cycle, exactly one run starts. Starts outside IDLE are ignored and not queued.
- On start, msg_sel is latched into a pending mask. Later msg_sel changes do not affect the run.
- FSM states:
  - IDLE: on start, go to SCAN.
  - SCAN: priority-encode the lowest set bit of the pending mask. Load cur_msg, clear that bit, char index=0, go to LOAD. If the mask is empty, go to FIN.
  - LOAD: ROM read (1-cycle registered), go to SEND. If the message length is 0, skip the message and its separator and go to SCAN.
  - SEND: tx_valid=1 with ROM byte. On tx_valid&&tx_ready, increment char index. If char index = len-1, go to SEP; otherwise go to LOAD.
  - SEP: tx_valid=1, tx_data=SEP_CHAR. On handshake, go to SCAN.
  - FIN: done=1 for one cycle, go to IDLE.
- Handshake: tx_data is held stable while tx_valid=1 and tx_ready=0. tx_valid never drops without a handshake, except on rst.
- An empty mask at start yields SCAN→FIN: done pulses and no byte is sent.
- Auto counter: runs only while auto_en=1 and the FSM is in IDLE. It clears on rst, on auto_en=0, and on every start. A zero mask in auto mode still pulses done every period.
- auto_en falling mid-run: the current run completes normally.
- rst mid-operation: everything returns to reset values next cycle. A partially sent message is abandoned, with no separator.

## Timing
- go high in cycle k: SCAN at k+1, LOAD at k+2, tx_valid=1 at k+3.
- Per character: at least 2 cycles (LOAD+SEND) with tx_ready tied high. The separator costs 1 cycle.
- done is asserted in the cycle after the last separator handshake plus the SCAN cycle, i.e. 2 cycles after it. busy falls together with done.
- Auto mode: consecutive starts are spaced at least AUTO_PERIOD cycles plus the run duration.

## Structure
- Package msg_pkg: state enum (IDLE, SCAN, LOAD, SEND, SEP, FIN), the width functions, and default ROM contents (char array and length table). Defaults: 0="ENGINEERING"(11), 1="ASSIGNMENT"(10), 2="STUDENT"(7), 3="FPGA"(4).
- Sub-module msg_rom: registered read, address {msg_idx, char_idx}; outputs byte and length. The sequencer FSM stays in the top module.

## Test plan
- msg_sel=4'b1000, go pulse, tx_ready=1 → bytes 0x46,0x50,0x47,0x41,0x20; first tx_valid 3 cycles after go; one done pulse; busy low afterwards.
- msg_sel=4'b0101, go → "ENGINEERING " then "STUDENT ", 20 bytes; cur_msg is 0 then 2.
- tx_ready held low for 50 cycles mid-message → tx_data/tx_valid stable throughout; no byte lost or duplicated.
- msg_sel changed to 4'b0010 and go pulsed again during a run → original mask completes; second go ignored.
- AUTO_PERIOD=16, auto_en=1, msg_sel=4'b1000 → "FPGA " repeats with start spacing ≥16 idle cycles; auto_en=0 mid-run → run finishes, no further starts.
- rst asserted during the third byte → next cycle tx_valid=0, busy=0, cur_msg=0. go afterwards restarts from the first byte. Also msg_sel=0, go → done pulse with zero bytes sent.

Source files
------------

// File: rtl/msg_pkg.sv
// Shared types, width helpers and default message contents for the message sequencer.
package msg_pkg;

  typedef enum logic [2:0] {IDLE, SCAN, LOAD, SEND, SEP, FIN} state_t;

  function automatic int mi_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int ci_width(input int m);
    return $clog2(m + 1);
  endfunction

  localparam int DEF_NUM_MSGS = 4;

  // Text is right-justified in each word, so character 0 sits in the highest used byte.
  localparam logic [127:0] DEF_TEXT [DEF_NUM_MSGS] = '{
    128'("ENGINEERING"), 128'("ASSIGNMENT"), 128'("STUDENT"), 128'("FPGA")
  };
  localparam int DEF_LEN [DEF_NUM_MSGS] = '{11, 10, 7, 4};

  function automatic logic [7:0] def_char(input int m, input int c);
    if (m >= DEF_NUM_MSGS || c >= DEF_LEN[m]) return 8'h00;
    return DEF_TEXT[m][(DEF_LEN[m] - 1 - c) * 8 +: 8];
  endfunction

endpackage

// File: rtl/msg_rom.sv
// Message store: registered read of one character plus the length of the addressed message.
module msg_rom
  import msg_pkg::*;
#(
  parameter int NUM_MSGS    = 4,
  parameter int MSG_LEN_MAX = 16,
  parameter int DATA_W      = 8,
  parameter int MI_W        = mi_width(NUM_MSGS),
  parameter int CI_W        = ci_width(MSG_LEN_MAX)
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic [MI_W-1:0]   msg_idx,
  input  logic [CI_W-1:0]   char_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic [CI_W-1:0]   rd_len
);

  // Messages beyond the default table read as empty; long defaults are clipped.
  function automatic int len_of(input int m);
    int l;
    l = (m < DEF_NUM_MSGS && m < NUM_MSGS) ? DEF_LEN[m] : 0;
    return (l > MSG_LEN_MAX) ? MSG_LEN_MAX : l;
  endfunction

  always_ff @(posedge sysclk) begin
    if (rst) begin
      rd_data <= '0;
      rd_len  <= '0;
    end else begin
      rd_data <= DATA_W'(def_char(int'(msg_idx), int'(char_idx)));
      rd_len  <= CI_W'(len_of(int'(msg_idx)));
    end
  end

endmodule

// File: rtl/msg_sequencer.sv
// Streams the messages selected by msg_sel, each followed by a separator, over valid/ready.
//   state | meaning
//   IDLE  | waiting for go or the auto tick
//   SCAN  | pick lowest pending message, or finish when none remain
//   LOAD  | ROM read of the current character in flight
//   SEND  | presenting a message character
//   SEP   | presenting the separator
//   FIN   | one-cycle done pulse
module msg_sequencer
  import msg_pkg::*;
#(
  parameter int                NUM_MSGS    = 4,
  parameter int                MSG_LEN_MAX = 16,
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] SEP_CHAR    = DATA_W'(8'h20),
  parameter int                AUTO_PERIOD = 2**25,
  localparam int               MI_W        = mi_width(NUM_MSGS),
  localparam int               CI_W        = ci_width(MSG_LEN_MAX)
) (
  input  logic                sysclk,
  input  logic                rst,
  input  logic [NUM_MSGS-1:0] msg_sel,
  input  logic                go,
  input  logic                auto_en,
  output logic [DATA_W-1:0]   tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic                done,
  output logic [MI_W-1:0]     cur_msg
);

  localparam int CNT_W = $clog2(AUTO_PERIOD);

  state_t              state;
  logic [NUM_MSGS-1:0] pending;
  logic [CI_W-1:0]     char_idx, rom_char, rom_len;
  logic [MI_W-1:0]     scan_idx, rom_msg;
  logic [DATA_W-1:0]   rom_data;
  logic [CNT_W-1:0]    auto_cnt;
  logic                auto_tick, start;

  always_comb begin
    scan_idx = '0;
    for (int i = NUM_MSGS - 1; i >= 0; i--)
      if (pending[i]) scan_idx = MI_W'(i);
  end

  assign auto_tick = auto_en && (auto_cnt == CNT_W'(AUTO_PERIOD - 1));
  assign start     = (state == IDLE) && (go || auto_tick);

  // Address the next message during SCAN so its length is ready by LOAD.
  assign rom_msg  = (state == SCAN) ? scan_idx : cur_msg;
  assign rom_char = (state == SCAN) ? '0 : char_idx;

  msg_rom #(
    .NUM_MSGS   (NUM_MSGS),
    .MSG_LEN_MAX(MSG_LEN_MAX),
    .DATA_W     (DATA_W),
    .MI_W       (MI_W),
    .CI_W       (CI_W)
  ) u_rom (
    .sysclk  (sysclk),
    .rst     (rst),
    .msg_idx (rom_msg),
    .char_idx(rom_char),
    .rd_data (rom_data),
    .rd_len  (rom_len)
  );

  assign tx_data = (state == SEP)  ? SEP_CHAR :
                   (state == SEND) ? rom_data : '0;

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= '0;
      cur_msg  <= '0;
      char_idx <= '0;
      auto_cnt <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (!auto_en || start)  auto_cnt <= '0;
      else if (state == IDLE) auto_cnt <= auto_cnt + CNT_W'(1);

      case (state)
        IDLE: if (start) begin
          pending <= msg_sel;
          busy    <= 1'b1;
          state   <= SCAN;
        end
        SCAN: if (pending == '0) begin
          done  <= 1'b1;
          state <= FIN;
        end else begin
          cur_msg           <= scan_idx;
          pending[scan_idx] <= 1'b0;
          char_idx          <= '0;
          state             <= LOAD;
        end
        LOAD: if (rom_len == '0) begin
          state <= SCAN;
        end else begin
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        SEND: if (tx_ready) begin
          char_idx <= char_idx + CI_W'(1);
          if (char_idx == rom_len - CI_W'(1)) begin
            state <= SEP;
          end else begin
            tx_valid <= 1'b0;
            state    <= LOAD;
          end
        end
        SEP: if (tx_ready) begin
          tx_valid <= 1'b0;
          state    <= SCAN;
        end
        FIN: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          cur_msg <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
